// File: rtl/fb_sprite_writer.sv
// Sprite blitter: copies a SPR_W x SPR_H sprite from an asynchronous ROM
// into a row-major framebuffer. It handles one pixel per cycle, skips
// transparent pixels, and clips pixels that fall off the screen edges.
module fb_sprite_writer #(
    parameter int FB_WIDTH    = 160,
    parameter int FB_HEIGHT   = 120,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int CIDXW       = 4,
    parameter int SPR_DEPTH   = 256,
    parameter int TRANSPARENT = 0,
    localparam int SPR_ADDRW  = $clog2(SPR_DEPTH),
    localparam int FB_ADDRW   = $clog2(FB_WIDTH * FB_HEIGHT),
    localparam int XW         = $clog2(FB_WIDTH),
    localparam int YW         = $clog2(FB_HEIGHT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [XW-1:0]        x_i,
    input  logic [YW-1:0]        y_i,
    input  logic [SPR_ADDRW-1:0] spr_base_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [SPR_ADDRW-1:0] rom_addr_o,
    input  logic [CIDXW-1:0]     rom_data_i,
    output logic                 fb_we_o,
    output logic [FB_ADDRW-1:0]  fb_addr_o,
    output logic [CIDXW-1:0]     fb_data_o
);

    // Counter widths are kept at least one bit wide so that 1-pixel sprites still elaborate.
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [SPR_ADDRW-1:0]   base_q, base_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic                   fb_we_q, fb_we_d;
    logic [FB_ADDRW-1:0]    fb_addr_q, fb_addr_d;
    logic [CIDXW-1:0]       fb_data_q, fb_data_d;

    // The extra bit on the screen coordinates lets an off-screen pixel be
    // clipped instead of wrapping back onto the screen.
    logic [XW:0]            xs;
    logic [YW:0]            ys;
    logic                   on_screen;

    assign xs        = (XW+1)'(x_q) + (XW+1)'(col_q);
    assign ys        = (YW+1)'(y_q) + (YW+1)'(row_q);
    assign on_screen = (xs < (XW+1)'(FB_WIDTH)) && (ys < (YW+1)'(FB_HEIGHT));

    // The ROM address wraps modulo 2^SPR_ADDRW. In IDLE and DONE the
    // counters are zero, so the address equals the latched base.
    assign rom_addr_o = base_q + SPR_ADDRW'(int'(row_q) * SPR_W + int'(col_q));
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign fb_we_o    = fb_we_q;
    assign fb_addr_o  = fb_addr_q;
    assign fb_data_o  = fb_data_q;

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            base_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            col_q     <= col_d;
            row_q     <= row_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
        end
    end

    // Next state: latch the draw on start, then scan the sprite row-major and register one write per cycle.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        base_d    = base_q;
        col_d     = col_q;
        row_d     = row_q;
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d     = x_i;
                    y_d     = y_i;
                    base_d  = spr_base_i;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                fb_addr_d = FB_ADDRW'(int'(ys) * FB_WIDTH + int'(xs));
                fb_data_d = rom_data_i;
                fb_we_d   = (rom_data_i != CIDXW'(TRANSPARENT)) && on_screen;
                if (col_q == CW'(SPR_W - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(SPR_H - 1)) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fb_sprite_writer.sv
// Directed bench for fb_sprite_writer: 8x4 framebuffer, 2x2 sprite, 8-word ROM.
module tb_fb_sprite_writer;

    localparam int FBW = 8, FBH = 4, SW = 2, SH = 2, CW = 4, DEPTH = 8;
    localparam int AW = 3, FAW = 5, XW = 3, YW = 2;

    logic           clk = 1'b0;
    logic           rst, start, busy, done, fb_we;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [AW-1:0]  base, rom_addr;
    logic [CW-1:0]  rom_data, fb_data;
    logic [FAW-1:0] fb_addr;
    logic [CW-1:0]  rom [DEPTH];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    fb_sprite_writer #(
        .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .SPR_W(SW), .SPR_H(SH),
        .CIDXW(CW), .SPR_DEPTH(DEPTH), .TRANSPARENT(0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .x_i(x), .y_i(y),
        .spr_base_i(base), .busy_o(busy), .done_o(done),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .fb_we_o(fb_we),
        .fb_addr_o(fb_addr), .fb_data_o(fb_data)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        x    = XW'($urandom);
        y    = YW'($urandom);
        base = AW'($urandom);
    endtask

    // One full draw from IDLE. ew/ea/ed hold the hand-computed enable,
    // address and data for pixels 0..3.
    task automatic draw(input string tag, input logic [XW-1:0] dx,
                        input logic [YW-1:0] dy, input logic [AW-1:0] db,
                        input logic [3:0] ew, input logic [3:0][7:0] ea,
                        input logic [3:0][3:0] ed, input bit rnd);
        x = dx; y = dy; base = db; start = 1'b1;
        step();                                     // edge 0
        start = 1'b0;
        if (rnd) scramble();
        chk({tag, " e0 busy"}, int'(busy), 1);
        chk({tag, " e0 we"}, int'(fb_we), 0);
        chk({tag, " e0 done"}, int'(done), 0);
        for (int k = 0; k < 4; k++) begin
            step();                                 // edge k+1
            if (rnd) scramble();
            chk($sformatf("%s px%0d we", tag, k), int'(fb_we), int'(ew[k]));
            if (ew[k]) begin
                chk($sformatf("%s px%0d addr", tag, k), int'(fb_addr), int'(ea[k]));
                chk($sformatf("%s px%0d data", tag, k), int'(fb_data), int'(ed[k]));
            end
            chk($sformatf("%s px%0d done", tag, k), int'(done), (k == 3) ? 1 : 0);
            chk($sformatf("%s px%0d busy", tag, k), int'(busy), 1);
        end
        step();                                     // back to IDLE
        chk({tag, " end done"}, int'(done), 0);
        chk({tag, " end busy"}, int'(busy), 0);
        chk({tag, " end we"}, int'(fb_we), 0);
    endtask

    initial begin
        rom[0] = 4'd1; rom[1] = 4'd0; rom[2] = 4'd3; rom[3] = 4'd4;
        rom[4] = 4'd5; rom[5] = 4'd6; rom[6] = 4'd7; rom[7] = 4'd8;
        rst = 1'b1; start = 1'b0; x = '0; y = '0; base = '0;
        repeat (3) step();
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst we", int'(fb_we), 0);
        chk("rst addr", int'(fb_addr), 0);
        chk("rst data", int'(fb_data), 0);
        chk("rst rom_addr", int'(rom_addr), 0);
        rst = 1'b0;
        step();

        // Basic draw: pixel 1 is transparent, so address 10 is skipped.
        draw("basic", 3'd1, 2'd1, 3'd0, 4'b1101,
             {8'd18, 8'd17, 8'd10, 8'd9}, {4'd4, 4'd3, 4'd0, 4'd1}, 1'b0);

        // Bottom-right corner: only pixel 0 lands on screen.
        draw("clip", 3'd7, 2'd3, 3'd4, 4'b0001,
             {8'd0, 8'd0, 8'd0, 8'd31}, {4'd0, 4'd0, 4'd0, 4'd5}, 1'b0);

        // In IDLE the ROM address follows the latched base, not the input.
        base = 3'd2;
        step();
        chk("idle rom_addr", int'(rom_addr), 4);
        chk("idle we", int'(fb_we), 0);

        // Start held high: draws repeat with one IDLE cycle between them.
        begin
            logic [3:0][7:0] ha;
            logic [3:0][3:0] hd;
            ha = {8'd9, 8'd8, 8'd1, 8'd0};
            hd = {4'd8, 4'd7, 4'd6, 4'd5};
            x = 3'd0; y = 2'd0; base = 3'd4; start = 1'b1;
            step();
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    step();
                    chk($sformatf("held d%0d px%0d we", d, k), int'(fb_we), 1);
                    chk($sformatf("held d%0d px%0d addr", d, k), int'(fb_addr), int'(ha[k]));
                    chk($sformatf("held d%0d px%0d data", d, k), int'(fb_data), int'(hd[k]));
                    chk($sformatf("held d%0d px%0d done", d, k), int'(done), (k == 3) ? 1 : 0);
                end
                if (d == 1) start = 1'b0;
                step();
                chk($sformatf("held d%0d idle busy", d), int'(busy), 0);
                chk($sformatf("held d%0d idle we", d), int'(fb_we), 0);
                if (d == 0) begin
                    step();
                    chk("held restart busy", int'(busy), 1);
                end
            end
        end

        // Reset at edge 2 aborts the draw: no more writes and no done pulse.
        x = 3'd1; y = 2'd1; base = 3'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("abort px0 we", int'(fb_we), 1);
        chk("abort px0 addr", int'(fb_addr), 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort we", int'(fb_we), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("abort quiet%0d done", i), int'(done), 0);
            chk($sformatf("abort quiet%0d we", i), int'(fb_we), 0);
            chk($sformatf("abort quiet%0d busy", i), int'(busy), 0);
        end
        draw("post_abort", 3'd1, 2'd1, 3'd0, 4'b1101,
             {8'd18, 8'd17, 8'd10, 8'd9}, {4'd4, 4'd3, 4'd0, 4'd1}, 1'b0);

        // Reset and start on the same edge: reset wins and the block stays idle.
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_start busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst_start quiet%0d busy", i), int'(busy), 0);
            chk($sformatf("rst_start quiet%0d we", i), int'(fb_we), 0);
            chk($sformatf("rst_start quiet%0d done", i), int'(done), 0);
        end

        // Inputs change randomly after the latch; the write sequence must not change.
        draw("scramble", 3'd1, 2'd1, 3'd0, 4'b1101,
             {8'd18, 8'd17, 8'd10, 8'd9}, {4'd4, 4'd3, 4'd0, 4'd1}, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
